// File: rtl/fifo_wr_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_wr_ptr_ctrl
// Write-side pointer and flag controller for an asynchronous FIFO.
// The read pointer arrives gray-coded from the read clock domain and is
// synchronised here. The block keeps the binary write pointer, exports it
// gray-coded, and produces full / almost_full / level / overflow from the
// synchronised read pointer.
//
// Ports
//   clk                in   write-domain clock, rising edge
//   rst_n              in   asynchronous active-low reset
//   wr_req             in   producer write request
//   wr_ack             out  combinational: write accepted this cycle
//   wr_addr            out  RAM write address (registered)
//   wr_ptr_gray        out  gray write pointer for the read domain (registered)
//   rd_ptr_gray_async  in   gray read pointer from the read domain (unsynchronised)
//   full               out  FIFO full (registered)
//   almost_full        out  level >= AFULL_LEVEL (registered)
//   level              out  write-side (pessimistic) occupancy (registered)
//   overflow           out  sticky: write attempted while full
//   clr_ovf            in   synchronous clear of overflow
// -----------------------------------------------------------------------------
module fifo_wr_ptr_ctrl #(
    parameter int unsigned SZ_ADDR     = 3,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AFULL_LEVEL = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_req,
    output logic               wr_ack,
    output logic [SZ_ADDR-1:0] wr_addr,
    output logic [SZ_ADDR:0]   wr_ptr_gray,
    input  logic [SZ_ADDR:0]   rd_ptr_gray_async,
    output logic               full,
    output logic               almost_full,
    output logic [SZ_ADDR:0]   level,
    output logic               overflow,
    input  logic               clr_ovf
);

    localparam int unsigned PW = SZ_ADDR + 1;

    // Synchroniser chain: pure flop-to-flop, stage 0 takes the async input.
    logic [SYNC_STAGES-1:0][PW-1:0] rq_pipe;
    logic [PW-1:0]                  rq;
    logic [PW-1:0]                  rbin;

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] full_match;
    logic [PW-1:0] level_next;
    logic          full_next;
    logic          afull_next;
    logic          ovf_next;

    // Read-pointer synchroniser
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rq_pipe <= '0;
        end else begin
            rq_pipe <= {rq_pipe[SYNC_STAGES-2:0], rd_ptr_gray_async};
        end
    end

    assign rq = rq_pipe[SYNC_STAGES-1];

    // Gray to binary: each binary bit is the XOR of all gray bits at and above it.
    for (genvar g = 0; g < PW; g++) begin : g_gray2bin
        assign rbin[g] = ^(rq >> g);
    end

    assign wr_ack     = wr_req & ~full;
    assign wbin_next  = wbin + PW'(wr_ack);
    assign wgray_next = wbin_next ^ (wbin_next >> 1);

    // Full when the write pointer is exactly one lap ahead of the read pointer;
    // in gray code that is the read pointer with its top two bits inverted.
    assign full_match = {~rq[PW-1:PW-2], rq[PW-3:0]};
    assign full_next  = (wgray_next == full_match);

    // Modulo subtraction handles pointer wrap without special cases.
    assign level_next = wbin_next - rbin;
    assign afull_next = (level_next >= PW'(AFULL_LEVEL));

    // Set wins over clear.
    assign ovf_next = (wr_req & full) | (overflow & ~clr_ovf);

    // Pointer and flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin        <= '0;
            wr_ptr_gray <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            level       <= '0;
            overflow    <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            wr_ptr_gray <= wgray_next;
            full        <= full_next;
            almost_full <= afull_next;
            level       <= level_next;
            overflow    <= ovf_next;
        end
    end

    assign wr_addr = wbin[SZ_ADDR-1:0];

endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_ptr_ctrl
// Self-checking bench: directed fill / overflow / drain / glitch / async-reset
// scenarios plus a randomized phase, all compared against a count-based model
// of the FIFO (write count, read count, read-pointer latency queue).
// -----------------------------------------------------------------------------
module tb_fifo_wr_ptr_ctrl;

    localparam int unsigned SZ_ADDR     = 3;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned AFULL_LEVEL = 6;
    localparam int unsigned PW          = SZ_ADDR + 1;
    localparam int          DEPTH       = 1 << SZ_ADDR;
    localparam int          PTR_MOD     = 2 * DEPTH;

    logic               clk;
    logic               rst_n;
    logic               wr_req;
    logic               wr_ack;
    logic [SZ_ADDR-1:0] wr_addr;
    logic [PW-1:0]      wr_ptr_gray;
    logic [PW-1:0]      rd_ptr_gray_async;
    logic               full;
    logic               almost_full;
    logic [PW-1:0]      level;
    logic               overflow;
    logic               clr_ovf;

    fifo_wr_ptr_ctrl #(
        .SZ_ADDR    (SZ_ADDR),
        .SYNC_STAGES(SYNC_STAGES),
        .AFULL_LEVEL(AFULL_LEVEL)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .wr_req           (wr_req),
        .wr_ack           (wr_ack),
        .wr_addr          (wr_addr),
        .wr_ptr_gray      (wr_ptr_gray),
        .rd_ptr_gray_async(rd_ptr_gray_async),
        .full             (full),
        .almost_full      (almost_full),
        .level            (level),
        .overflow         (overflow),
        .clr_ovf          (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: plain counts of writes and reads.
    int m_wcnt;
    int m_rcnt;
    int rd_q[$];
    int m_level;
    bit m_full;
    bit m_af;
    bit m_ovf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] to_gray(input int n);
        logic [PW-1:0] b;
        b = PW'(n % PTR_MOD);
        return b ^ (b >> 1);
    endfunction

    task automatic model_reset();
        m_wcnt  = 0;
        m_rcnt  = 0;
        m_level = 0;
        m_full  = 1'b0;
        m_af    = 1'b0;
        m_ovf   = 1'b0;
        rd_q    = {};
        for (int i = 0; i < int'(SYNC_STAGES); i++) rd_q.push_back(0);
    endtask

    task automatic check_outputs();
        check("wr_addr",     32'(wr_addr),     32'(m_wcnt % DEPTH));
        check("wr_ptr_gray", 32'(wr_ptr_gray), 32'(to_gray(m_wcnt)));
        check("level",       32'(level),       32'(m_level));
        check("full",        32'(full),        32'(m_full));
        check("almost_full", 32'(almost_full), 32'(m_af));
        check("overflow",    32'(overflow),    32'(m_ovf));
    endtask

    // One clock: drive at negedge, check wr_ack, update model at posedge, check.
    task automatic step(input bit req, input bit clr, input int rd_cnt);
        bit            ack;
        int            used;
        logic [PW-1:0] prev_gray;
        wr_req            = req;
        clr_ovf           = clr;
        rd_ptr_gray_async = to_gray(rd_cnt);
        #1;
        ack = req && !m_full;
        check("wr_ack", 32'(wr_ack), 32'(ack));
        prev_gray = wr_ptr_gray;
        @(posedge clk);
        if (req && m_full) m_ovf = 1'b1;
        else if (clr)      m_ovf = 1'b0;
        if (ack) m_wcnt++;
        rd_q.push_back(rd_cnt);
        used    = rd_q.pop_front();
        m_level = m_wcnt - used;
        m_full  = (m_level == DEPTH);
        m_af    = (m_level >= int'(AFULL_LEVEL));
        #1;
        check_outputs();
        check("gray_bits_changed", 32'($countones(wr_ptr_gray ^ prev_gray)), 32'(ack));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit req;
        bit clr;
        int rd_pct;

        rst_n             = 1'b0;
        wr_req            = 1'b0;
        clr_ovf           = 1'b0;
        rd_ptr_gray_async = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_outputs();
        check("reset_wr_ack", 32'(wr_ack), 32'(0));
        rst_n = 1'b1;

        // Fill with the read pointer parked at zero.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, 0);
            check("fill_afull", 32'(almost_full), 32'((i + 1) >= int'(AFULL_LEVEL)));
        end
        check("fill_gray_const", 32'(wr_ptr_gray), 32'h0000_000C);
        check("fill_level_const", 32'(level), 32'(DEPTH));

        // Overflow: request while full, clear, then set and clear together.
        step(1'b1, 1'b0, 0);
        step(1'b0, 1'b1, 0);
        step(1'b1, 1'b1, 0);
        step(1'b0, 1'b1, 0);

        // Drain latency: one read appears on the async input.
        m_rcnt = 1;
        step(1'b0, 1'b0, m_rcnt);
        step(1'b0, 1'b0, m_rcnt);
        check("drain_still_full", 32'(full), 32'(1));
        step(1'b0, 1'b0, m_rcnt);
        check("drain_full_clear", 32'(full), 32'(0));
        check("drain_level", 32'(level), 32'(DEPTH - 1));
        step(1'b1, 1'b0, m_rcnt);

        // Glitch: the read pointer steps ahead for one cycle and reverts.
        for (int i = 0; i < 3; i++) begin
            m_rcnt++;
            step(1'b0, 1'b0, m_rcnt);
        end
        step(1'b0, 1'b0, m_rcnt + 1);
        for (int i = 0; i < int'(SYNC_STAGES) + 2; i++) step(1'b0, 1'b0, m_rcnt);
        check("glitch_level_settled", 32'(level), 32'(m_wcnt - m_rcnt));

        // Randomized traffic: slow reader then fast reader, occasional glitches.
        for (int i = 0; i < 400; i++) begin
            rd_pct = (i < 200) ? 30 : 70;
            req    = ($urandom_range(0, 99) < 60);
            clr    = ($urandom_range(0, 15) == 0);
            if (m_rcnt < m_wcnt && $urandom_range(0, 99) < rd_pct) m_rcnt++;
            if (m_rcnt < m_wcnt && $urandom_range(0, 31) == 0)
                step(req, clr, m_rcnt + 1);
            else
                step(req, clr, m_rcnt);
        end

        // Async reset mid-burst, between clock edges.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, m_rcnt);
        wr_req = 1'b1;
        #2;
        rst_n  = 1'b0;
        wr_req = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check("areset_wr_ack", 32'(wr_ack), 32'(0));
        rd_ptr_gray_async = '0;
        @(negedge clk);
        rst_n = 1'b1;
        check("post_reset_addr0", 32'(wr_addr), 32'(0));
        step(1'b1, 1'b0, 0);
        check("post_reset_addr1", 32'(wr_addr), 32'(1));
        step(1'b1, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
